// File: rtl/mix_trace_tx.sv
// rtl/mix_trace_tx.sv - MIX register trace line transmitter over 8N1 UART
//
// Purpose:
//   On each retired MIX instruction (step strobe) snapshots pc, A, X and J and
//   sends them as one 43-character ASCII octal line:
//      "P pppp A saaaaaaaaaa X sxxxxxxxxxx J jjjj" CR LF
//   over an 8N1 UART, so a board run can be traced like a bench run.
//
// Ports:
//   clk      in   1   system clock, rising edge
//   reset    in   1   asynchronous, active-low reset
//   enable   in   1   1 = tracing on; 0 = step ignored
//   step     in   1   one-cycle strobe, register inputs valid
//   pc       in   12  program counter
//   reg_a    in   31  register A, [30]=sign (1=minus), [29:0]=magnitude
//   reg_x    in   31  register X, same format
//   reg_j    in   12  register J
//   tx       out  1   UART serial output, idle high
//   busy     out  1   snapshot held or being sent
//   dropped  out  1   one-cycle pulse: step arrived while busy
//   hold     out  1   only with MIX_TRACE_STALL_EN: core must freeze while 1
//
// Configuration macro: MIX_TRACE_STALL_EN
//   defined   -> hold port present, hold = busy | (step & enable), dropped tied 0
//   undefined -> no hold port, overlapping steps discarded and flagged on dropped

module mix_trace_tx #(
   parameter int CLK_HZ  = 12000000,
   parameter int BAUD    = 115200,
   parameter int DIVISOR = CLK_HZ / BAUD
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        step,
   input  logic [11:0] pc,
   input  logic [30:0] reg_a,
   input  logic [30:0] reg_x,
   input  logic [11:0] reg_j,
   output logic        tx,
   output logic        busy,
   output logic        dropped
`ifdef MIX_TRACE_STALL_EN
   ,
   output logic        hold
`endif
);

   localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam logic [CW-1:0] CNT_MAX  = CW'(DIVISOR - 1);
   localparam logic [5:0]    LAST_IDX = 6'd42;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [5:0]    idx_q, idx_d;
   logic [7:0]    sh_q, sh_d;
   logic [11:0]   pc_q, j_q;
   logic [30:0]   a_q, x_q;
   logic          tx_q, tx_d;
   logic          accept;
   logic [7:0]    char_c;

   // Octal digit k (0 = most significant) of a 30-bit magnitude.
   function automatic logic [7:0] oct30(input logic [29:0] v, input logic [5:0] k);
      return 8'h30 | {5'b0, 3'(v >> (6'd27 - 6'd3 * k))};
   endfunction

   // Octal digit k (0 = most significant) of a 12-bit word.
   function automatic logic [7:0] oct12(input logic [11:0] v, input logic [5:0] k);
      return 8'h30 | {5'b0, 3'(v >> (6'd9 - 6'd3 * k))};
   endfunction

   function automatic logic [7:0] sign_char(input logic s);
      return s ? 8'h2D : 8'h2B;
   endfunction

   assign accept = step & enable & (state_q == S_IDLE);
   assign busy   = (state_q != S_IDLE);
   assign tx     = tx_q;

   // Character at position idx_q of the line; positions not listed are spaces.
   always_comb begin
      char_c = 8'h20;
      if (idx_q == 6'd0)
         char_c = 8'h50;
      else if (idx_q >= 6'd2 && idx_q <= 6'd5)
         char_c = oct12(pc_q, idx_q - 6'd2);
      else if (idx_q == 6'd7)
         char_c = 8'h41;
      else if (idx_q == 6'd9)
         char_c = sign_char(a_q[30]);
      else if (idx_q >= 6'd10 && idx_q <= 6'd19)
         char_c = oct30(a_q[29:0], idx_q - 6'd10);
      else if (idx_q == 6'd21)
         char_c = 8'h58;
      else if (idx_q == 6'd23)
         char_c = sign_char(x_q[30]);
      else if (idx_q >= 6'd24 && idx_q <= 6'd33)
         char_c = oct30(x_q[29:0], idx_q - 6'd24);
      else if (idx_q == 6'd35)
         char_c = 8'h4A;
      else if (idx_q >= 6'd37 && idx_q <= 6'd40)
         char_c = oct12(j_q, idx_q - 6'd37);
      else if (idx_q == 6'd41)
         char_c = 8'h0D;
      else if (idx_q == 6'd42)
         char_c = 8'h0A;
   end

   // tx_d is the line level belonging to the current state; it is registered
   // into tx_q so the pin is glitch-free, which puts the start bit of char 0
   // two cycles after the capture edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      idx_d   = idx_q;
      sh_d    = sh_q;
      tx_d    = 1'b1;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               idx_d   = 6'd0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            sh_d    = char_c;
            cnt_d   = '0;
            state_d = S_START;
         end
         S_START: begin
            tx_d = 1'b0;
            if (cnt_q == CNT_MAX) begin
               cnt_d   = '0;
               bit_d   = 3'd0;
               state_d = S_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            tx_d = sh_q[0];
            if (cnt_q == CNT_MAX) begin
               cnt_d = '0;
               sh_d  = {1'b0, sh_q[7:1]};
               if (bit_q == 3'd7)
                  state_d = S_STOP;
               else
                  bit_d = bit_q + 3'd1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            tx_d = 1'b1;
            if (cnt_q == CNT_MAX) begin
               cnt_d = '0;
               if (idx_q == LAST_IDX) begin
                  state_d = S_IDLE;
               end else begin
                  idx_d   = idx_q + 6'd1;
                  state_d = S_LOAD;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         idx_q   <= 6'd0;
         sh_q    <= 8'd0;
         pc_q    <= 12'd0;
         a_q     <= 31'd0;
         x_q     <= 31'd0;
         j_q     <= 12'd0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         idx_q   <= idx_d;
         sh_q    <= sh_d;
         tx_q    <= tx_d;
         if (accept) begin
            pc_q <= pc;
            a_q  <= reg_a;
            x_q  <= reg_x;
            j_q  <= reg_j;
         end
      end
   end

`ifdef MIX_TRACE_STALL_EN
   // The core freezes while hold is high, so no step can be lost.
   assign hold    = busy | (step & enable);
   assign dropped = 1'b0;
`else
   logic dropped_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         dropped_q <= 1'b0;
      else
         dropped_q <= step & enable & busy;
   end

   assign dropped = dropped_q;
`endif

endmodule

// File: tb/tb_mix_trace_tx.sv
// tb/tb_mix_trace_tx.sv - scoreboard bench for mix_trace_tx with UART receiver model
module tb_mix_trace_tx;

   localparam int D  = 4;
   localparam int L  = 43 * (10 * D + 1);
   localparam int L2 = 43 * (10 * 104 + 1);

   logic        clk = 1'b0;
   logic        reset, enable, step, reset2, step2;
   logic [11:0] pc, reg_j;
   logic [30:0] reg_a, reg_x;
   logic        tx, busy, dropped, tx2, busy2, dropped2;
`ifdef MIX_TRACE_STALL_EN
   logic        hold, hold2;
`endif

   always #5 clk = ~clk;

   mix_trace_tx #(.DIVISOR(D)) u_dut (
      .clk(clk), .reset(reset), .enable(enable), .step(step),
      .pc(pc), .reg_a(reg_a), .reg_x(reg_x), .reg_j(reg_j),
      .tx(tx), .busy(busy), .dropped(dropped)
`ifdef MIX_TRACE_STALL_EN
      , .hold(hold)
`endif
   );

   mix_trace_tx #(.DIVISOR(104)) u_dut2 (
      .clk(clk), .reset(reset2), .enable(1'b1), .step(step2),
      .pc(pc), .reg_a(reg_a), .reg_x(reg_x), .reg_j(reg_j),
      .tx(tx2), .busy(busy2), .dropped(dropped2)
`ifdef MIX_TRACE_STALL_EN
      , .hold(hold2)
`endif
   );

   int         vectors = 0, miscompares = 0;
   int         cyc = 0, drop_cnt = 0, drop2_cnt = 0, epoch = 0;
   int         exp_drop = 0, last_acc = 0;
   bit         has_line = 0;
   logic [7:0] exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (dropped === 1'b1) drop_cnt <= drop_cnt + 1;
   always @(negedge clk) if (dropped2 === 1'b1) drop2_cnt <= drop2_cnt + 1;

   task automatic check(input string name, input longint act, input longint req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: the line text straight from the field definitions.
   task automatic push_line(input logic [11:0] p, input logic [30:0] a, input logic [30:0] x,
                            input logic [11:0] j);
      string s;
      s = $sformatf("P %o A %s%o X %s%o J %o", p, a[30] ? "-" : "+", a[29:0],
                    x[30] ? "-" : "+", x[29:0], j);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask

   // Called #1 after a rising edge; the step is sampled at the next edge.
   // A line keeps the transmitter busy for L cycles after its capture edge.
   task automatic do_step(input logic [11:0] p, input logic [30:0] a, input logic [30:0] x,
                          input logic [11:0] j, input logic en);
      int samp;
      samp  = cyc + 1;
      pc    = p;
      reg_a = a;
      reg_x = x;
      reg_j = j;
      enable = en;
      step  = 1'b1;
      if (en) begin
         if (!has_line || samp - last_acc > L) begin
            has_line = 1;
            last_acc = samp;
            push_line(p, a, x, j);
         end else begin
`ifndef MIX_TRACE_STALL_EN
            exp_drop++;
`endif
         end
      end
      tick();
      step  = 1'b0;
      pc    = 12'($urandom);
      reg_a = 31'($urandom);
      reg_x = 31'($urandom);
      reg_j = 12'($urandom);
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 3 * L) begin
         tick();
         n++;
      end
      check({name, "_drain_in_time"}, (n < 3 * L) ? 1 : 0, 1);
      repeat (10) tick();
      check({name, "_tx_idle"}, tx, 1);
      check({name, "_busy_low"}, busy, 0);
      check({name, "_dropped_count"}, drop_cnt, exp_drop);
   endtask

   // Monitor: UART receiver sampling mid-bit, compares each char with the scoreboard.
   initial begin : monitor
      int         ep;
      logic [7:0] b, e;
      logic       okf;
      forever begin
         @(negedge clk);
         if (reset === 1'b1 && tx === 1'b0) begin
            ep = epoch;
            repeat (D / 2) @(negedge clk);
            okf = (tx === 1'b0);
            for (int i = 0; i < 8; i++) begin
               repeat (D) @(negedge clk);
               b[i] = tx;
            end
            repeat (D) @(negedge clk);
            okf = okf & (tx === 1'b1);
            if (ep == epoch) begin
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_char: got 0x%02h expected no character", b);
               end else begin
                  e = exp_q.pop_front();
                  check("char", b, e);
                  check("framing", okf, 1);
               end
            end
         end
      end
   end

   initial begin : main
      int bad, s0, choice, target;
      reset = 1'b0; reset2 = 1'b0; enable = 1'b0; step = 1'b0; step2 = 1'b0;
      pc = '0; reg_a = '0; reg_x = '0; reg_j = '0;
      repeat (3) tick();
      check("reset_tx", tx, 1);
      check("reset_busy", busy, 0);
      check("reset_dropped", dropped, 0);
      reset = 1'b1;
      reset2 = 1'b1;
      tick();
      fork
         begin : main_tests
            // directed lines
            do_step(12'o0005, 31'o17, 31'd0, 12'o0006, 1'b1);
            check("t1_busy_rise", busy, 1);
            wait_drain("t1");
            do_step(12'($urandom), {1'b1, 30'o7777777777}, 31'o2000000001, 12'($urandom), 1'b1);
            wait_drain("t2");
            // overlapping step is dropped
            do_step(12'o1234, 31'o3456, 31'o7654, 12'o4321, 1'b1);
            repeat (48) tick();
            do_step(12'o7777, 31'o1111, 31'o2222, 12'o3333, 1'b1);
            wait_drain("t3");
            // tracing disabled
            bad = 0;
            for (int k = 0; k < 3; k++) begin
               do_step(12'($urandom), 31'($urandom), 31'($urandom), 12'($urandom), 1'b0);
               repeat (5) begin
                  tick();
                  if (tx !== 1'b1 || busy !== 1'b0 || dropped !== 1'b0) bad++;
               end
            end
            check("t6_disabled_quiet", bad, 0);
            check("t6_dropped_count", drop_cnt, exp_drop);
            // reset in DATA bit 3 of char 5
            do_step(12'($urandom), 31'($urandom), 31'($urandom), 12'($urandom), 1'b1);
            s0 = cyc;
            while (cyc < s0 + 223) tick();
            reset = 1'b0;
            epoch++;
            exp_q.delete();
            has_line = 0;
            #1;
            check("t4_tx_at_reset", tx, 1);
            check("t4_busy_at_reset", busy, 0);
            bad = 0;
            repeat (20) begin
               @(negedge clk);
               if (tx !== 1'b1) bad++;
            end
            check("t4_no_edges_in_reset", bad, 0);
            tick();
            reset = 1'b1;
            repeat (40) tick();
            do_step(12'($urandom), 31'($urandom), 31'($urandom), 12'($urandom), 1'b1);
            wait_drain("t4_after");
            // randomized gaps: back-to-back, short (possibly dropped), long
            for (int r = 0; r < 8; r++) begin
               choice = int'($urandom_range(0, 2));
               if (choice == 0)      target = last_acc + L + 1;
               else if (choice == 1) target = cyc + int'($urandom_range(2, 400));
               else                  target = last_acc + L + int'($urandom_range(2, 60));
               while (cyc + 1 < target) tick();
               do_step(12'($urandom), 31'($urandom), 31'($urandom), 12'($urandom), 1'b1);
            end
            wait_drain("rand");
         end
         begin : t5_full_divisor
            int s, lat, run;
            step2 = 1'b1;
            s = cyc + 1;
            tick();
            step2 = 1'b0;
            lat = 0;
            while (tx2 !== 1'b0 && lat < 10) begin tick(); lat++; end
            check("t5_start_latency", lat, 2);
            // 'P' = 8'h50: start plus four zero data bits, then a single one bit
            run = 0;
            while (tx2 === 1'b0 && run < 2000) begin tick(); run++; end
            check("t5_low_run_5_bits", run, 5 * 104);
            run = 0;
            while (tx2 === 1'b1 && run < 2000) begin tick(); run++; end
            check("t5_high_run_1_bit", run, 104);
            while (busy2 === 1'b1 && cyc - s < L2 + 1000) tick();
            check("t5_busy_length", cyc - s, L2);
            // back-to-back: step in the busy-fall cycle
            step2 = 1'b1;
            tick();
            step2 = 1'b0;
            lat = 0;
            while (tx2 !== 1'b0 && lat < 10) begin tick(); lat++; end
            check("t5_b2b_latency", lat, 2);
            check("t5_dropped2", drop2_cnt, 0);
         end
      join
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
